// File: rtl/line_decoder_seq_pkg.sv
// Shared definitions for the line-select decoder used by the storage arrays
// (register file and cache tag/data/valid arrays).
//
// Contents:
//   state_e   - two-state controller encoding (ST_IDLE / ST_SWEEP)
//   lines_of  - number of selectable lines for a given address width
package line_decoder_seq_pkg;

  // Controller states. Encoding is fixed so checkers can bind to the raw bit.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  // Number of lines addressed by an aw-bit index.
  function automatic int lines_of(input int aw);
    return 1 << aw;
  endfunction

endpackage : line_decoder_seq_pkg

// File: rtl/line_decoder_seq_onehot_decoder.sv
// Purely combinational binary-to-one-hot decoder.
//
// Ports:
//   addr_i   [ADDR_W]       binary line index
//   onehot_o [2**ADDR_W]    bit addr_i set, all other bits clear
module onehot_decoder
  import line_decoder_seq_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic [ADDR_W-1:0]           addr_i,
  output logic [lines_of(ADDR_W)-1:0] onehot_o
);

  localparam int LINES = lines_of(ADDR_W);

  // One equality compare per output line; exactly one matches any index.
  for (genvar i = 0; i < LINES; i++) begin : g_line
    assign onehot_o[i] = (addr_i == ADDR_W'(i));
  end

endmodule : onehot_decoder

// File: rtl/line_decoder_seq.sv
// Registered N-to-2^N line-select decoder with a single-access path and a
// full-array sweep path (flush / valid-bit clear).
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is the only combinational
// input-to-output path; the requester must hold req_valid/req_addr stable
// until the transfer happens. All other outputs come straight from flops.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_valid    single-access request present
//   req_addr     line index of the request
//   req_ready    request can be accepted this cycle
//   sweep_start  begin a full-array sweep (honoured only when idle)
//   sweep_busy   sweep in progress
//   sweep_done   one-cycle pulse in the cycle after the last swept line
//   line_sel     registered one-hot line select, zero when idle
//   line_valid   line_sel holds a live selection
//   line_idx     binary index of the selected line (zero when not valid)
module line_decoder_seq
  import line_decoder_seq_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  input  logic [ADDR_W-1:0]           req_addr,
  output logic                        req_ready,
  input  logic                        sweep_start,
  output logic                        sweep_busy,
  output logic                        sweep_done,
  output logic [lines_of(ADDR_W)-1:0] line_sel,
  output logic                        line_valid,
  output logic [ADDR_W-1:0]           line_idx
);

  localparam int LINES = lines_of(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LINES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q,   cnt_d;
  logic [LINES-1:0]  sel_q,   sel_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] idx_q,   idx_d;
  logic              done_q,  done_d;

  logic [LINES-1:0]  dec_out;

  // State register: controller state, sweep counter and all registered
  // outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. idx_d is the mux of request address and next counter
  // value; it feeds the single shared decoder.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    idx_d   = '0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sweep_start) begin
          // Sweep wins over a simultaneous request; the request stays pending.
          state_d = ST_SWEEP;
          cnt_d   = '0;
          valid_d = 1'b1;
          idx_d   = '0;
        end else if (req_valid) begin
          valid_d = 1'b1;
          idx_d   = req_addr;
        end
      end
      ST_SWEEP: begin
        if (cnt_q == LAST_IDX) begin
          // Terminal compare ends the sweep, so the counter never wraps.
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + ADDR_W'(1);
          valid_d = 1'b1;
          idx_d   = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  onehot_decoder #(
    .ADDR_W (ADDR_W)
  ) u_dec (
    .addr_i   (idx_d),
    .onehot_o (dec_out)
  );

  // Gate the decoder so an idle cycle registers an all-zero select.
  assign sel_d = valid_d ? dec_out : '0;

  // Output logic.
  always_comb begin
    req_ready  = (state_q == ST_IDLE) && !sweep_start;
    sweep_busy = (state_q == ST_SWEEP);
  end

  assign sweep_done = done_q;
  assign line_sel   = sel_q;
  assign line_valid = valid_q;
  assign line_idx   = idx_q;

endmodule : line_decoder_seq

// File: tb/tb_line_decoder_seq.sv
module tb_line_decoder_seq;

  localparam int AW    = 7;
  localparam int LINES = 1 << AW;
  localparam int NEVER = -1000000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             req_valid = 1'b0;
  logic [AW-1:0]    req_addr = '0;
  logic             req_ready;
  logic             sweep_start = 1'b0;
  logic             sweep_busy;
  logic             sweep_done;
  logic [LINES-1:0] line_sel;
  logic             line_valid;
  logic [AW-1:0]    line_idx;

  line_decoder_seq #(.ADDR_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done),
    .line_sel    (line_sel),
    .line_valid  (line_valid),
    .line_idx    (line_idx)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [AW-1:0] exp_q[$];      // accepted request addresses awaiting output
  int edge_cnt = 0;             // rising edges seen by the model
  int m_start  = NEVER;         // edge at which the current sweep began
  int seen [LINES];             // per-line selection counts during a sweep
  bit count_lines = 0;

  always @(negedge clk)
    assert ($countones(line_sel) <= 1) else $error("line_sel multi-hot %h", line_sel);

  task automatic chk(input string tag, input logic [LINES-1:0] got, input logic [LINES-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Sweep timeline rule: line d is shown in the cycle after edge start+d,
  // done pulses in the cycle after edge start+LINES.
  function automatic bit sweeping(input int e);
    int d = e - m_start;
    return (m_start != NEVER) && d >= 0 && d < LINES;
  endfunction

  task automatic check_outputs(input bit acc);
    int d;
    logic [LINES-1:0] e_sel;
    logic [AW-1:0] e_idx;
    bit e_valid, e_busy, e_done;
    d = edge_cnt - m_start;
    e_sel = '0; e_idx = '0; e_valid = 0; e_busy = 0; e_done = 0;
    if (sweeping(edge_cnt)) begin
      e_sel[d] = 1'b1; e_idx = AW'(d); e_valid = 1; e_busy = 1;
      if (count_lines) seen[d]++;
    end else if (m_start != NEVER && d == LINES) begin
      e_done = 1;
    end else if (acc) begin
      e_idx = exp_q.pop_front();
      e_sel[e_idx] = 1'b1; e_valid = 1;
    end
    chk("line_sel", line_sel, e_sel);
    chk("line_valid", {127'b0, line_valid}, {127'b0, e_valid});
    chk("sweep_busy", {127'b0, sweep_busy}, {127'b0, e_busy});
    chk("sweep_done", {127'b0, sweep_done}, {127'b0, e_done});
    if (e_valid) chk("line_idx", {121'b0, line_idx}, {121'b0, e_idx});
  endtask

  // ---------------- driver ----------------
  // Called #1 after a rising edge; drives one cycle and checks the result.
  task automatic step(input bit sv, input bit rv, input logic [AW-1:0] ra, output bit acc);
    bit busy_now, beg;
    sweep_start = sv;
    req_valid   = rv;
    req_addr    = rv ? ra : AW'($urandom);
    #1;
    busy_now = sweeping(edge_cnt);
    chk("req_ready", {127'b0, req_ready}, {127'b0, !busy_now && !sv});
    acc = rv && !busy_now && !sv;
    beg = sv && !busy_now;
    if (acc) exp_q.push_back(ra);
    @(posedge clk);
    edge_cnt++;
    if (beg) m_start = edge_cnt;
    #1;
    check_outputs(acc);
  endtask

  task automatic idle_cycles(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(0, 0, '0, a);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit a;
    int n, ones;
    logic [AW-1:0] hold_addr;

    #3;
    chk("rst_sel", line_sel, '0);
    chk("rst_valid", {127'b0, line_valid}, '0);
    chk("rst_idx", {121'b0, line_idx}, '0);
    chk("rst_busy", {127'b0, sweep_busy}, '0);
    chk("rst_done", {127'b0, sweep_done}, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // single access then drop
    step(0, 1, 7'd5, a);
    idle_cycles(1);

    // back-to-back accepts, no bubble
    step(0, 1, 7'd0, a);
    step(0, 1, 7'd127, a);
    step(0, 1, 7'd64, a);
    idle_cycles(2);

    // full sweep with per-line coverage, restart honoured in the done cycle
    for (int i = 0; i < LINES; i++) seen[i] = 0;
    count_lines = 1;
    step(1, 0, '0, a);
    idle_cycles(LINES);
    count_lines = 0;
    ones = 0;
    for (int i = 0; i < LINES; i++) if (seen[i] == 1) ones++;
    chk("sweep_each_line_once", LINES'(ones), LINES'(LINES));
    step(1, 0, '0, a);            // this is the sweep_done cycle
    idle_cycles(LINES + 2);

    // sweep_start and request together: request held, accepted in done cycle
    hold_addr = 7'd2;
    step(1, 1, hold_addr, a);
    n = 0;
    while (!a && n < 4 * LINES) begin
      step(0, 1, hold_addr, a);
      n++;
    end
    chk("hold_accepted", {127'b0, a}, {127'b0, 1'b1});
    chk("hold_acc_cycle", LINES'(edge_cnt - 1 - m_start), LINES'(LINES));
    idle_cycles(2);

    // restart mid-sweep ignored
    step(1, 0, '0, a);
    idle_cycles(10);
    step(1, 0, '0, a);
    step(1, 1, 7'd9, a);
    idle_cycles(LINES - 12);
    n = 0;
    while (!(sweep_done === 1'b1) && n < 8) begin idle_cycles(1); n++; end
    chk("restart_ignored_end", LINES'(edge_cnt - m_start), LINES'(LINES));
    idle_cycles(2);

    // reset mid-sweep at line 4: outputs clear asynchronously, no done
    step(1, 0, '0, a);
    idle_cycles(4);
    chk("pre_rst_idx", {121'b0, line_idx}, 128'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sel", line_sel, '0);
    chk("arst_valid", {127'b0, line_valid}, '0);
    chk("arst_idx", {121'b0, line_idx}, '0);
    chk("arst_busy", {127'b0, sweep_busy}, '0);
    chk("arst_done", {127'b0, sweep_done}, '0);
    m_start = NEVER;
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    edge_cnt++;
    #1;
    idle_cycles(LINES + 4);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 60) == 0, $urandom_range(0, 2) != 0, AW'($urandom), a);
    end
    idle_cycles(LINES + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_line_decoder_seq
